// File: rtl/i2c_read_word.sv
// I2C master that reads one 16-bit word from a slave register:
// START, addr(W), pointer, repeated START, addr(R), MSB (ACK), LSB (NACK), STOP.
module i2c_read_word #(
    parameter bit ABORT_ON_NACK = 1'b1
) (
    input  logic        RESET_N,
    input  logic        PT_CK,
    input  logic        GO,
    input  logic [7:0]  SLAVE_ADDRESS,
    input  logic [7:0]  POINTER,
    input  logic        SDAI,
    output logic        SDAO,
    output logic        SCLO,
    output logic        END_OK,
    output logic        ACK_OK,
    output logic [15:0] RDATA16
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ARM    = 4'd1;
    localparam logic [3:0] ST_START  = 4'd2;
    localparam logic [3:0] ST_B_LOW  = 4'd3;
    localparam logic [3:0] ST_B_DATA = 4'd4;
    localparam logic [3:0] ST_B_HIGH = 4'd5;
    localparam logic [3:0] ST_B_SAMP = 4'd6;
    localparam logic [3:0] ST_RS_A   = 4'd7;
    localparam logic [3:0] ST_RS_B   = 4'd8;
    localparam logic [3:0] ST_RS_C   = 4'd9;
    localparam logic [3:0] ST_RS_D   = 4'd10;
    localparam logic [3:0] ST_P_A    = 4'd11;
    localparam logic [3:0] ST_P_B    = 4'd12;
    localparam logic [3:0] ST_P_C    = 4'd13;
    localparam logic [3:0] ST_P_D    = 4'd14;
    localparam logic [3:0] ST_DONE   = 4'd15;

    logic [3:0]  state;
    logic [2:0]  byte_idx;
    logic [3:0]  bit_cnt;
    logic        read_done;
    logic [7:0]  tx_sr;
    logic [15:0] rx_sr;
    logic        ack_slot;
    logic        rd_byte;

    // bit_cnt is 0..8 in B_DATA and 1..9 in B_SAMP (incremented in B_HIGH)
    assign ack_slot = (bit_cnt == 4'd9);
    assign rd_byte  = (byte_idx >= 3'd3);

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            byte_idx  <= 3'd0;
            bit_cnt   <= 4'd0;
            read_done <= 1'b0;
            SDAO      <= 1'b1;
            SCLO      <= 1'b1;
            END_OK    <= 1'b1;
            ACK_OK    <= 1'b0;
            RDATA16   <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    SDAO   <= 1'b1;
                    SCLO   <= 1'b1;
                    END_OK <= 1'b1;
                    if (GO) state <= ST_ARM;
                end
                ST_ARM: begin
                    if (!GO) begin
                        END_OK <= 1'b0;
                        ACK_OK <= 1'b1;
                        state  <= ST_START;
                    end
                end
                ST_START: begin
                    SDAO      <= 1'b0;
                    byte_idx  <= 3'd0;
                    bit_cnt   <= 4'd0;
                    read_done <= 1'b0;
                    state     <= ST_B_LOW;
                end
                ST_B_LOW: begin
                    SCLO  <= 1'b0;
                    state <= ST_B_DATA;
                end
                ST_B_DATA: begin
                    // Master releases on its own ACK slots; ACKs the MSB, NACKs the LSB
                    if (!rd_byte) SDAO <= (bit_cnt == 4'd8) ? 1'b1 : tx_sr[7];
                    else          SDAO <= (bit_cnt == 4'd8) ? (byte_idx == 3'd4) : 1'b1;
                    state <= ST_B_HIGH;
                end
                ST_B_HIGH: begin
                    SCLO    <= 1'b1;
                    bit_cnt <= bit_cnt + 4'd1;
                    state   <= ST_B_SAMP;
                end
                ST_B_SAMP: begin
                    if (!ack_slot) begin
                        state <= ST_B_LOW;
                    end else begin
                        bit_cnt <= 4'd0;
                        if (!rd_byte && SDAI) ACK_OK <= 1'b0;
                        if (!rd_byte && SDAI && ABORT_ON_NACK) begin
                            state <= ST_P_A;
                        end else if (byte_idx == 3'd4) begin
                            read_done <= 1'b1;
                            state     <= ST_P_A;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= (byte_idx == 3'd1) ? ST_RS_A : ST_B_LOW;
                        end
                    end
                end
                ST_RS_A: begin SCLO <= 1'b0; state <= ST_RS_B; end
                ST_RS_B: begin SDAO <= 1'b1; state <= ST_RS_C; end
                ST_RS_C: begin SCLO <= 1'b1; state <= ST_RS_D; end
                ST_RS_D: begin SDAO <= 1'b0; state <= ST_B_LOW; end
                ST_P_A:  begin SCLO <= 1'b0; state <= ST_P_B; end
                ST_P_B:  begin SDAO <= 1'b0; state <= ST_P_C; end
                ST_P_C:  begin SCLO <= 1'b1; state <= ST_P_D; end
                ST_P_D:  begin SDAO <= 1'b1; state <= ST_DONE; end
                ST_DONE: begin
                    END_OK <= 1'b1;
                    if (read_done) RDATA16 <= rx_sr;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Shift registers carry data only, so they are left out of reset
    always_ff @(posedge PT_CK) begin
        case (state)
            ST_START:  tx_sr <= SLAVE_ADDRESS & 8'hFE;
            ST_RS_D:   tx_sr <= SLAVE_ADDRESS | 8'h01;
            ST_B_DATA: tx_sr <= {tx_sr[6:0], 1'b0};
            ST_B_SAMP: begin
                if (ack_slot && byte_idx == 3'd0) tx_sr <= POINTER;
                else if (!ack_slot && rd_byte)    rx_sr <= {rx_sr[14:0], SDAI};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_read_word.sv
// Bench for i2c_read_word: bus-level slave model, table of transactions,
// plus hand-written reset and held-GO sequences.
module tb_i2c_read_word;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go_a = 1'b0;
    logic go_b = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] ptr = 8'h00;
    logic sdao_a, sclo_a, end_ok_a, ack_ok_a;
    logic sdao_b, sclo_b, end_ok_b, ack_ok_b;
    logic [15:0] rdata_a, rdata_b;
    logic sl_sda = 1'b1;
    logic sda, scl;

    assign sda = sdao_a & sdao_b & sl_sda;
    assign scl = sclo_a & sclo_b;

    always #5 clk = ~clk;

    i2c_read_word #(.ABORT_ON_NACK(1'b1)) dut_a (
        .RESET_N(rst_n), .PT_CK(clk), .GO(go_a), .SLAVE_ADDRESS(addr), .POINTER(ptr),
        .SDAI(sda), .SDAO(sdao_a), .SCLO(sclo_a), .END_OK(end_ok_a), .ACK_OK(ack_ok_a),
        .RDATA16(rdata_a));

    i2c_read_word #(.ABORT_ON_NACK(1'b0)) dut_b (
        .RESET_N(rst_n), .PT_CK(clk), .GO(go_b), .SLAVE_ADDRESS(addr), .POINTER(ptr),
        .SDAI(sda), .SDAO(sdao_b), .SCLO(sclo_b), .END_OK(end_ok_b), .ACK_OK(ack_ok_b),
        .RDATA16(rdata_b));

    // Slave model
    logic [2:0]  nack_cfg = 3'b000;
    logic [15:0] rd_word = 16'h0000;
    int clr_req = 0;
    int clr_seen = 0;
    int s_bit = 0;
    int s_byte = 0;
    int hi_falls = 0;
    int hi_rises = 0;
    logic s_blk = 1'b0;
    logic [7:0] s_sr = 8'h00;
    logic [7:0] seen [5];
    logic ack_bit [5];
    logic sda_q = 1'b1;
    logic scl_q = 1'b1;

    always @(sda, scl, clr_req) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            s_bit = 0; s_byte = 0; hi_falls = 0; hi_rises = 0;
            s_blk = 1'b0; sl_sda = 1'b1;
            for (int k = 0; k < 5; k++) begin seen[k] = 8'h00; ack_bit[k] = 1'b0; end
        end else begin
            if (scl && scl_q && sda_q && !sda) begin hi_falls++; s_bit = 0; end
            if (scl && scl_q && !sda_q && sda) hi_rises++;
            if (scl && !scl_q) begin
                if (s_bit < 8) s_sr = {s_sr[6:0], sda};
                else if (s_byte < 5) begin seen[s_byte] = s_sr; ack_bit[s_byte] = sda; end
                s_bit++;
                if (s_bit == 9) begin s_bit = 0; s_byte++; end
            end
            if (!scl && scl_q) begin
                sl_sda = 1'b1;
                if (s_bit == 8 && s_byte < 3) begin
                    sl_sda = nack_cfg[s_byte];
                    if (s_byte == 2 && nack_cfg[2]) s_blk = 1'b1;
                end else if ((s_byte == 3 || s_byte == 4) && s_bit < 8 && !s_blk) begin
                    sl_sda = rd_word[(s_byte == 3 ? 15 : 7) - s_bit];
                end
            end
        end
        sda_q = sda;
        scl_q = scl;
    end

    int ends_a = 0;
    always @(negedge end_ok_a) ends_a++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic reset_slave();
        clr_req = clr_req + 1;
        #1;
        clr_req = clr_req + 1;
        #1;
    endtask

    // Pulse GO, then count PT_CK edges after E0 until END_OK reads 1
    task automatic run_txn(input logic b, output int n);
        @(negedge clk);
        if (b) go_b = 1'b1; else go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0; go_b = 1'b0;
        @(posedge clk); #1;
        n = 0;
        while ((b ? end_ok_b : end_ok_a) !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    typedef struct {
        logic        use_b;
        logic [7:0]  addr;
        logic [7:0]  ptr;
        logic [2:0]  nack;
        logic [15:0] sdata;
        int          cyc;
        logic        ack;
        logic [15:0] rdata;
        int          falls;
        logic        full;
    } vec_t;

    vec_t vt [8];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int e0;
        logic [15:0] rd_sel;
        vt[0] = '{1'b0, 8'h90, 8'h05, 3'b000, 16'h1A2B, 190, 1'b1, 16'h1A2B, 2, 1'b1};
        vt[1] = '{1'b0, 8'h90, 8'h05, 3'b001, 16'h3C4D,  42, 1'b0, 16'h1A2B, 1, 1'b0};
        vt[2] = '{1'b0, 8'h90, 8'h05, 3'b010, 16'h3C4D,  78, 1'b0, 16'h1A2B, 1, 1'b0};
        vt[3] = '{1'b0, 8'h90, 8'h05, 3'b100, 16'h3C4D, 118, 1'b0, 16'h1A2B, 2, 1'b0};
        vt[4] = '{1'b0, 8'hA3, 8'hFF, 3'b000, 16'h00FF, 190, 1'b1, 16'h00FF, 2, 1'b1};
        vt[5] = '{1'b1, 8'h90, 8'h05, 3'b010, 16'h55AA, 190, 1'b0, 16'h55AA, 2, 1'b1};
        vt[6] = '{1'b1, 8'h91, 8'h22, 3'b100, 16'h1234, 190, 1'b0, 16'hFFFF, 2, 1'b1};
        vt[7] = '{1'b1, 8'h90, 8'h05, 3'b000, 16'h8001, 190, 1'b1, 16'h8001, 2, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdao", 32'(sdao_a), 32'd1);
        chk("rst_sclo", 32'(sclo_a), 32'd1);
        chk("rst_end_ok", 32'(end_ok_a), 32'd1);
        chk("rst_ack_ok", 32'(ack_ok_a), 32'd0);
        chk("rst_rdata", 32'(rdata_a), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            addr = vt[i].addr; ptr = vt[i].ptr; nack_cfg = vt[i].nack; rd_word = vt[i].sdata;
            reset_slave();
            run_txn(vt[i].use_b, n);
            rd_sel = vt[i].use_b ? rdata_b : rdata_a;
            chk($sformatf("v%0d_low_cycles", i), 32'(n), 32'(vt[i].cyc));
            chk($sformatf("v%0d_ack_ok", i), 32'(vt[i].use_b ? ack_ok_b : ack_ok_a), 32'(vt[i].ack));
            chk($sformatf("v%0d_rdata", i), 32'(rd_sel), 32'(vt[i].rdata));
            chk($sformatf("v%0d_sda_fall_scl_high", i), 32'(hi_falls), 32'(vt[i].falls));
            chk($sformatf("v%0d_sda_rise_scl_high", i), 32'(hi_rises), 32'd1);
            if (vt[i].full) begin
                chk($sformatf("v%0d_byte0", i), 32'(seen[0]), 32'(vt[i].addr & 8'hFE));
                chk($sformatf("v%0d_byte1", i), 32'(seen[1]), 32'(vt[i].ptr));
                chk($sformatf("v%0d_byte2", i), 32'(seen[2]), 32'(vt[i].addr | 8'h01));
                chk($sformatf("v%0d_byte3", i), 32'(seen[3]), 32'(vt[i].rdata[15:8]));
                chk($sformatf("v%0d_byte4", i), 32'(seen[4]), 32'(vt[i].rdata[7:0]));
                chk($sformatf("v%0d_master_ack", i), 32'(ack_bit[3]), 32'd0);
                chk($sformatf("v%0d_master_nack", i), 32'(ack_bit[4]), 32'd1);
            end
        end

        // Reset asserted at E100 of a read on dut_a
        addr = 8'h90; ptr = 8'h05; nack_cfg = 3'b000; rd_word = 16'h1A2B;
        reset_slave();
        @(negedge clk); go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        @(posedge clk); #1;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_sdao", 32'(sdao_a), 32'd1);
        chk("midrst_sclo", 32'(sclo_a), 32'd1);
        chk("midrst_end_ok", 32'(end_ok_a), 32'd1);
        chk("midrst_ack_ok", 32'(ack_ok_a), 32'd0);
        chk("midrst_rdata", 32'(rdata_a), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        reset_slave();
        run_txn(1'b0, n);
        chk("postrst_low_cycles", 32'(n), 32'd190);
        chk("postrst_ack_ok", 32'(ack_ok_a), 32'd1);
        chk("postrst_rdata", 32'(rdata_a), 32'h1A2B);
        chk("postrst_sda_fall_scl_high", 32'(hi_falls), 32'd2);

        // GO re-raised right after E0 and held through E195
        rd_word = 16'h6E7F;
        reset_slave();
        e0 = ends_a;
        @(negedge clk); go_a = 1'b1;
        @(negedge clk); go_a = 1'b0;
        @(posedge clk); #1;
        go_a = 1'b1;
        n = 0;
        while (end_ok_a !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk("held_first_low_cycles", 32'(n), 32'd190);
        reset_slave();
        repeat (5) @(posedge clk);
        @(negedge clk); go_a = 1'b0;
        @(posedge clk); #1;
        chk("held_second_start", 32'(end_ok_a), 32'd0);
        n = 0;
        while (end_ok_a !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk("held_second_low_cycles", 32'(n), 32'd190);
        chk("held_second_rdata", 32'(rdata_a), 32'h6E7F);
        repeat (300) @(posedge clk);
        #1;
        chk("held_txn_count", 32'(ends_a - e0), 32'd2);
        chk("held_idle_end_ok", 32'(end_ok_a), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_read_word.md
# i2c_read_word

I2C master that reads one 16-bit word from a slave register. It is the read-side companion of the word-write controller on the same user-IO I2C bus, and runs on the same PT_CK step clock. A transaction is: START, slave address (write), 8-bit register pointer, repeated START, slave address (read), MSB byte (master ACK), LSB byte (master NACK), STOP. The result is presented on RDATA16 with an END_OK done flag.

## Interface
- ABORT_ON_NACK, 1, 1: a slave NACK on any of the three master-sent bytes jumps straight to STOP. 0: the transaction completes anyway, with ACK_OK low.
- RESET_N  in  1  asynchronous, active-low reset
- PT_CK  in  1  step clock; one protocol step per rising edge; 4 steps per SCL bit
- GO  in  1  request pulse; a transaction starts on GO falling after GO was seen high in IDLE
- SLAVE_ADDRESS  in  8  address byte; bit 0 is replaced (0 for the write phase, 1 for the read phase)
- POINTER  in  8  slave register pointer
- SDAI  in  1  bus SDA sampled value
- SDAO  out  1  SDA drive (1 = release)
- SCLO  out  1  SCL drive (1 = release)
- END_OK  out  1  1 = idle/done, 0 = transaction in progress
- ACK_OK  out  1  1 = every slave ACK of the last transaction was low
- RDATA16  out  16  last successfully read word, {MSB, LSB}

## Operation
- Reset values: SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, RDATA16=0x0000, state IDLE, byte index 0. Assertion mid-transaction takes effect immediately and abandons the bus transaction without a STOP.
- IDLE: SDAO=1, SCLO=1, END_OK=1. GO=1 moves to ARM.
- ARM: on GO=0, set END_OK<=0 and ACK_OK<=1, then go to START.
- START (1 cycle): SDAO<=0 while SCLO=1. Load the shift register with {SLAVE_ADDRESS[7:1],0}. Set byte index to 0.
- Each bit takes four states:
  - B_LOW: SCLO<=0
  - B_DATA: SDAO<=bit
  - B_HIGH: SCLO<=1, bit count +1
  - B_SAMP: sample SDAI
- Bits 1-8 go out MSB first. Bit 9 is the ACK slot.
- Bytes 0-2 (address write, pointer, address read): SDAO drives the data bits and releases (1) in the ACK slot.
  - If SDAI=1 in the ACK slot, ACK_OK<=0.
  - If ABORT_ON_NACK=1, go to the STOP sequence; RDATA16 is not updated.
- Bytes 3-4 (read data): SDAO=1 for bits 1-8, and SDAI is shifted in MSB first in B_SAMP. In the ACK slot, SDAO=0 after byte 3 and SDAO=1 after byte 4.
- After the byte 1 ACK, run the repeated START:
  - RS_A: SCLO<=0
  - RS_B: SDAO<=1
  - RS_C: SCLO<=1
  - RS_D: SDAO<=0
  - Then load {SLAVE_ADDRESS[7:1],1}.
- After the byte 4 ACK slot, or on abort, run STOP:
  - P_A: SCLO<=0
  - P_B: SDAO<=0
  - P_C: SCLO<=1
  - P_D: SDAO<=1
- DONE (1 cycle): END_OK<=1. If all 5 bytes completed, RDATA16<={byte3,byte4}. Then go to IDLE.
- GO high during a transaction is ignored. If GO is still high at DONE, IDLE→ARM follows, and exactly one further transaction starts on GO falling.
- No clock stretching and no arbitration: SCL is not read back.

## Timing
- Edge E0 is the PT_CK edge at which ARM sees GO=0; END_OK reads 0 after E0.
- Full read:
  - START at E1
  - bytes 0-1 at E2-E73
  - repeated START at E74-E77
  - bytes 2-4 at E78-E185
  - STOP at E186-E189
  - DONE at E190
  - END_OK is low for exactly 190 PT_CK cycles.
- Abort (ABORT_ON_NACK=1), END_OK low duration: 42 cycles on a byte 0 NACK, 78 on byte 1, 118 on byte 2.
- SDA changes only while SCLO=0, except for START, repeated START and STOP. SDAI is sampled one cycle after the SCLO rise.
- RDATA16 and ACK_OK are valid when END_OK rises and hold until the next DONE.

## Test plan
- Read word: slave model ACKs address 0x90, pointer 0x05 and 0x91, and returns 0x1A then 0x2B → RDATA16=0x1A2B, ACK_OK=1, END_OK low 190 cycles. SDA bytes seen are 0x90, 0x05, 0x91; master ACK=0 after 0x1A, NACK=1 after 0x2B.
- Bus shape: check that SDA never toggles while SCL is high except at 1 START, 1 repeated START and 1 STOP per transaction.
- Address NACK, ABORT_ON_NACK=1 → STOP after byte 0, END_OK low 42 cycles, ACK_OK=0, RDATA16 keeps its prior value 0x1A2B.
- Pointer NACK with ABORT_ON_NACK=0 → full 190-cycle transaction, ACK_OK=0, RDATA16 updated with the slave data.
- RESET_N low at E100 → SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, RDATA16=0 immediately. The next GO pulse performs a clean 190-cycle read.
- GO held high from E0 through E195, then low → exactly two transactions; the second starts at the GO fall.
